// File: rtl/sync_fifo_wr_arbiter_if.sv
// ============================================================================
// Module   : sync_fifo_wr_arbiter_if
// Brief    : Requester-side and FIFO-write-side bundle for sync_fifo_wr_arbiter
// Revision : 1.0
// ============================================================================
`default_nettype none

interface sync_fifo_wr_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int DIN_WIDTH = 4
);
  localparam int GID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*DIN_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]           req_last;
  logic [NUM_REQ-1:0]           req_ready;
  logic [DIN_WIDTH-1:0]         fifo_din;
  logic                         fifo_wr_en;
  logic                         fifo_full;
  logic                         fifo_almost_full;
  logic [GID_W-1:0]             grant_id;
  logic                         busy;
  logic                         burst_done;

  modport slave (
    input  req_valid, req_data, req_last, fifo_full, fifo_almost_full,
    output req_ready, fifo_din, fifo_wr_en, grant_id, busy, burst_done
  );

  modport master (
    output req_valid, req_data, req_last, fifo_full, fifo_almost_full,
    input  req_ready, fifo_din, fifo_wr_en, grant_id, busy, burst_done
  );
endinterface

`default_nettype wire

// File: rtl/sync_fifo_wr_arbiter.sv
// ============================================================================
// Module   : sync_fifo_wr_arbiter
// Brief    : Round-robin, packet/burst-capped arbiter in front of a FIFO write port
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_fifo_wr_arbiter #(
  parameter  int NUM_REQ   = 4,
  parameter  int DIN_WIDTH = 4,
  parameter  int MAX_BURST = 8,
  localparam int CNT_WIDTH = $clog2(MAX_BURST + 1),
  localparam int GID_W     = $clog2(NUM_REQ)
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  sync_fifo_wr_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t               state_q;
  logic [GID_W-1:0]     rr_ptr_q;
  logic [GID_W-1:0]     rr_ptr_d;
  logic [GID_W-1:0]     grant_id_q;
  logic [CNT_WIDTH-1:0] beat_cnt_q;
  logic                 burst_done_q;

  logic [DIN_WIDTH-1:0] w_slice [NUM_REQ];
  logic [NUM_REQ-1:0]   w_ready;
  logic                 w_pick_found;
  logic [GID_W-1:0]     w_pick_idx;
  logic [GID_W:0]       w_cand_sum;
  logic                 w_accept;
  logic                 w_last_beat;
  logic                 w_release;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign w_slice[gi] = bus.req_data[gi*DIN_WIDTH +: DIN_WIDTH];
    end
  endgenerate

  // Scan downward so the candidate closest to rr_ptr is the one left standing.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_idx   = '0;
    w_cand_sum   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_cand_sum = {1'b0, rr_ptr_q} + (GID_W + 1)'(k);
      if (w_cand_sum >= (GID_W + 1)'(NUM_REQ)) begin
        w_cand_sum = w_cand_sum - (GID_W + 1)'(NUM_REQ);
      end
      if (bus.req_valid[w_cand_sum[GID_W-1:0]]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = w_cand_sum[GID_W-1:0];
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (state_q == GRANT && !bus.fifo_full) begin
      w_ready[grant_id_q] = 1'b1;
    end
  end

  assign w_accept    = (state_q == GRANT) && bus.req_valid[grant_id_q] && !bus.fifo_full;
  assign w_last_beat = bus.req_last[grant_id_q] ||
                       (beat_cnt_q == CNT_WIDTH'(MAX_BURST - 1));
  assign w_release   = w_accept && w_last_beat;
  assign rr_ptr_d    = (grant_id_q == GID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_id_q   <= '0;
      beat_cnt_q   <= '0;
      burst_done_q <= 1'b0;
    end else begin
      burst_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (w_pick_found && !bus.fifo_almost_full) begin
            grant_id_q <= w_pick_idx;
            beat_cnt_q <= '0;
            state_q    <= GRANT;
          end
        end
        GRANT: begin
          if (w_accept) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
          end
          if (w_release) begin
            state_q      <= IDLE;
            rr_ptr_q     <= rr_ptr_d;
            burst_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.fifo_wr_en = w_accept;
  assign bus.fifo_din   = w_slice[grant_id_q];
  assign bus.grant_id   = grant_id_q;
  assign bus.busy       = (state_q == GRANT);
  assign bus.burst_done = burst_done_q;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_wr_arbiter.sv
// ============================================================================
// Module   : tb_sync_fifo_wr_arbiter
// Brief    : Directed vector table plus scoreboarded sequences for the arbiter
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sync_fifo_wr_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  sync_fifo_wr_arbiter_if #(.NUM_REQ(4), .DIN_WIDTH(4)) bus ();

  sync_fifo_wr_arbiter #(
    .NUM_REQ  (4),
    .DIN_WIDTH(4),
    .MAX_BURST(8)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    logic        rst_n;
    logic [3:0]  valid;
    logic [15:0] data;
    logic [3:0]  last;
    logic [3:0]  ready;
    logic        wr;
    logic [3:0]  din;
    logic [1:0]  gid;
    logic        busy;
    logic        bd;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(logic r, logic [3:0] v, logic [15:0] d, logic [3:0] l,
                              logic [3:0] rdy, logic wr, logic [3:0] din, logic [1:0] gid,
                              logic busy, logic bd);
    vec_t t;
    t.rst_n = r; t.valid = v; t.data = d; t.last = l;
    t.ready = rdy; t.wr = wr; t.din = din; t.gid = gid; t.busy = busy; t.bd = bd;
    return t;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          idx0;
    int          idx2;
    int          fullcnt;
    bit          sent1;
    logic [1:0]  exp_gid [$];
    logic [3:0]  exp_din [$];
    logic [1:0]  log_gid [$];
    logic [3:0]  log_din [$];

    // Reset, single requester, then continuous 1-beat round robin.
    vecs[0]  = mk(0, 4'hF,    16'h0000, 4'h0,    4'h0,    0, 4'h0, 2'd0, 0, 0);
    vecs[1]  = mk(0, 4'hF,    16'h0000, 4'h0,    4'h0,    0, 4'h0, 2'd0, 0, 0);
    vecs[2]  = mk(0, 4'hF,    16'h0000, 4'h0,    4'h0,    0, 4'h0, 2'd0, 0, 0);
    vecs[3]  = mk(1, 4'b0100, 16'h0100, 4'h0,    4'h0,    0, 4'h0, 2'd0, 0, 0);
    vecs[4]  = mk(1, 4'b0100, 16'h0100, 4'h0,    4'b0100, 1, 4'h1, 2'd2, 1, 0);
    vecs[5]  = mk(1, 4'b0100, 16'h0200, 4'h0,    4'b0100, 1, 4'h2, 2'd2, 1, 0);
    vecs[6]  = mk(1, 4'b0100, 16'h0300, 4'b0100, 4'b0100, 1, 4'h3, 2'd2, 1, 0);
    vecs[7]  = mk(1, 4'h0,    16'h0000, 4'h0,    4'h0,    0, 4'h0, 2'd2, 0, 1);
    vecs[8]  = mk(1, 4'hF,    16'hDCBA, 4'hF,    4'h0,    0, 4'h0, 2'd2, 0, 0);
    vecs[9]  = mk(1, 4'hF,    16'hDCBA, 4'hF,    4'b1000, 1, 4'hD, 2'd3, 1, 0);
    vecs[10] = mk(1, 4'hF,    16'hDCBA, 4'hF,    4'h0,    0, 4'h0, 2'd3, 0, 1);
    vecs[11] = mk(1, 4'hF,    16'hDCBA, 4'hF,    4'b0001, 1, 4'hA, 2'd0, 1, 0);
    vecs[12] = mk(1, 4'hF,    16'hDCBA, 4'hF,    4'h0,    0, 4'h0, 2'd0, 0, 1);
    vecs[13] = mk(1, 4'hF,    16'hDCBA, 4'hF,    4'b0010, 1, 4'hB, 2'd1, 1, 0);
    vecs[14] = mk(1, 4'hF,    16'hDCBA, 4'hF,    4'h0,    0, 4'h0, 2'd1, 0, 1);
    vecs[15] = mk(1, 4'hF,    16'hDCBA, 4'hF,    4'b0100, 1, 4'hC, 2'd2, 1, 0);
    vecs[16] = mk(1, 4'hF,    16'hDCBA, 4'hF,    4'h0,    0, 4'h0, 2'd2, 0, 1);
    vecs[17] = mk(1, 4'hF,    16'hDCBA, 4'hF,    4'b1000, 1, 4'hD, 2'd3, 1, 0);
    vecs[18] = mk(1, 4'h0,    16'h0000, 4'h0,    4'h0,    0, 4'h0, 2'd3, 0, 1);

    rst_n                = 1'b0;
    bus.req_valid        = 4'hF;
    bus.req_data         = '0;
    bus.req_last         = '0;
    bus.fifo_full        = 1'b0;
    bus.fifo_almost_full = 1'b0;
    @(posedge clk);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      rst_n         = vecs[i].rst_n;
      bus.req_valid = vecs[i].valid;
      bus.req_data  = vecs[i].data;
      bus.req_last  = vecs[i].last;
      #1;
      chk($sformatf("v%0d_ready", i), bus.req_ready, vecs[i].ready);
      chk($sformatf("v%0d_wr_en", i), bus.fifo_wr_en, vecs[i].wr);
      chk($sformatf("v%0d_gid", i), bus.grant_id, vecs[i].gid);
      chk($sformatf("v%0d_busy", i), bus.busy, vecs[i].busy);
      chk($sformatf("v%0d_bdone", i), bus.burst_done, vecs[i].bd);
      if (vecs[i].wr) chk($sformatf("v%0d_din", i), bus.fifo_din, vecs[i].din);
    end

    // Burst cap: 20-beat packet on req 0 competing with a 1-beat packet on req 1.
    idx0  = 1;
    sent1 = 1'b0;
    for (int c = 0; c < 100 && !(idx0 > 20 && sent1); c++) begin
      @(negedge clk);
      bus.req_valid = {2'b00, ~sent1, (idx0 <= 20)};
      bus.req_data  = {8'h00, 4'hF, 4'(idx0)};
      bus.req_last  = {2'b00, 1'b1, (idx0 == 20)};
      #1;
      if (bus.fifo_wr_en) begin
        log_gid.push_back(bus.grant_id);
        log_din.push_back(bus.fifo_din);
      end
      if (bus.req_ready[0] && bus.req_valid[0]) idx0++;
      if (bus.req_ready[1] && bus.req_valid[1]) sent1 = 1'b1;
    end
    chk("t4_complete", {31'd0, (idx0 > 20 && sent1)}, 32'd1);
    for (int b = 1; b <= 8; b++)  begin exp_gid.push_back(2'd0); exp_din.push_back(4'(b)); end
    exp_gid.push_back(2'd1); exp_din.push_back(4'hF);
    for (int b = 9; b <= 20; b++) begin exp_gid.push_back(2'd0); exp_din.push_back(4'(b)); end
    chk("t4_count", log_gid.size(), exp_gid.size());
    for (int j = 0; j < exp_gid.size() && j < log_gid.size(); j++) begin
      chk($sformatf("t4_gid%0d", j), log_gid[j], exp_gid[j]);
      chk($sformatf("t4_din%0d", j), log_din[j], exp_din[j]);
    end

    // Full backpressure on beat 3 of a 6-beat packet from req 2.
    log_gid.delete(); log_din.delete();
    idx2    = 1;
    fullcnt = 0;
    for (int c = 0; c < 100 && idx2 <= 6; c++) begin
      @(negedge clk);
      bus.req_valid = 4'b0100;
      bus.req_data  = {4'h0, 4'(idx2), 8'h00};
      bus.req_last  = (idx2 == 6) ? 4'b0100 : 4'b0000;
      bus.fifo_full = (idx2 == 3 && fullcnt < 5);
      if (bus.fifo_full) fullcnt++;
      #1;
      if (bus.fifo_full) begin
        chk($sformatf("t5_wr_en_full%0d", fullcnt), bus.fifo_wr_en, 1'b0);
        chk($sformatf("t5_ready_full%0d", fullcnt), bus.req_ready, 4'h0);
        chk($sformatf("t5_busy_full%0d", fullcnt), bus.busy, 1'b1);
      end
      if (bus.fifo_wr_en) begin
        log_gid.push_back(bus.grant_id);
        log_din.push_back(bus.fifo_din);
      end
      if (bus.req_ready[2] && bus.req_valid[2]) idx2++;
    end
    bus.fifo_full = 1'b0;
    chk("t5_full_cycles", fullcnt, 5);
    chk("t5_count", log_gid.size(), 6);
    for (int j = 0; j < 6 && j < log_gid.size(); j++) begin
      chk($sformatf("t5_gid%0d", j), log_gid[j], 2'd2);
      chk($sformatf("t5_din%0d", j), log_din[j], 4'(j + 1));
    end

    // Almost-full gating in IDLE, then reset in the middle of a burst.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.req_valid        = 4'hF;
      bus.req_last         = 4'h0;
      bus.req_data         = 16'h4321;
      bus.fifo_almost_full = 1'b1;
      #1;
      chk($sformatf("t6_af_busy%0d", c), bus.busy, 1'b0);
      chk($sformatf("t6_af_ready%0d", c), bus.req_ready, 4'h0);
      chk($sformatf("t6_af_wr%0d", c), bus.fifo_wr_en, 1'b0);
    end
    @(negedge clk);
    bus.fifo_almost_full = 1'b0;
    #1;
    chk("t6_release_busy", bus.busy, 1'b0);
    @(negedge clk);
    bus.fifo_almost_full = 1'b1;
    #1;
    chk("t6_grant_busy", bus.busy, 1'b1);
    chk("t6_grant_gid", bus.grant_id, 2'd3);
    chk("t6_grant_ready", bus.req_ready, 4'b1000);
    chk("t6_grant_din", bus.fifo_din, 4'h4);
    @(negedge clk);
    rst_n                = 1'b0;
    bus.fifo_almost_full = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t6_rst_busy", bus.busy, 1'b0);
    chk("t6_rst_ready", bus.req_ready, 4'h0);
    chk("t6_rst_wr", bus.fifo_wr_en, 1'b0);
    chk("t6_rst_gid", bus.grant_id, 2'd0);
    @(negedge clk);
    #1;
    chk("t6_post_rst_busy", bus.busy, 1'b1);
    chk("t6_post_rst_gid", bus.grant_id, 2'd0);
    bus.req_valid = 4'h0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
